// File: rtl/monkey_action_ctrl.sv
// Monkey per-life action sequencer: mode FSM, key gating, death/respawn/lives.
// Optional jump buffer in AIR enabled by defining MONKEY_JUMP_BUFFER_EN.
module monkey_action_ctrl #(
  parameter int LIVES             = 3,
  parameter int RESPAWN_FRAMES    = 30,
  parameter int DYING_FRAMES      = 45,
  parameter int FALL_DEATH_FRAMES = 40
`ifdef MONKEY_JUMP_BUFFER_EN
  ,
  parameter int JUMP_BUFFER_FRAMES = 6
`endif
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       gameStart,
  input  logic       keyDigitValid,
  input  logic [3:0] keyDigit,
  input  logic       keyJump,
  input  logic       floorHit,
  input  logic       ropeHit,
  input  logic       hazardHit,
  input  logic       descending,
  output logic       digitIsPressed,
  output logic [3:0] digit,
  output logic       jumpIsPressed,
  output logic       moveResetN,
  output logic [2:0] state,
  output logic [1:0] livesLeft,
  output logic       gameOver
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_GROUND    = 3'd1,
    S_AIR       = 3'd2,
    S_ROPE      = 3'd3,
    S_DYING     = 3'd4,
    S_RESPAWN   = 3'd5,
    S_GAME_OVER = 3'd6
  } state_t;

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [7:0] RESP_LAST  = 8'(RESPAWN_FRAMES - 1);
  localparam logic [7:0] DYING_LAST = 8'(DYING_FRAMES - 1);
  localparam logic [7:0] FALL_LIM   = 8'(FALL_DEATH_FRAMES);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_lives;
  logic [1:0] w_livesNext;

  logic       r_floorSeen;
  logic       r_ropeSeen;
  logic       r_hazardSeen;
  logic       w_floor;
  logic       w_rope;
  logic       w_hazard;

  logic       r_keyJumpD;
  logic       w_jumpEdge;
  logic       w_groundJump;
  logic       r_jumpPending;
  logic       r_jump;
  logic       w_bufFire;

  logic [7:0] r_frameCnt;
  logic [7:0] r_fallCnt;
  logic       w_stateChange;
  logic       w_respDone;
  logic       w_dyingDone;
  logic       w_fallFatal;

  logic       w_digitLegal;
  logic       w_digitPass;
  logic       r_digitValid;
  logic [3:0] r_digit;
  logic       r_moveResetN;
  logic       r_gameOver;

  // Combined view of this frame's contacts, including the boundary cycle.
  assign w_floor  = r_floorSeen | floorHit;
  assign w_rope   = r_ropeSeen | ropeHit;
  assign w_hazard = r_hazardSeen | hazardHit;

  assign w_jumpEdge    = keyJump & ~r_keyJumpD;
  assign w_groundJump  = (r_state == S_GROUND) & w_jumpEdge;
  assign w_stateChange = (w_next != r_state);
  assign w_respDone    = startOfFrame & (r_frameCnt == RESP_LAST);
  assign w_dyingDone   = startOfFrame & (r_frameCnt == DYING_LAST);
  assign w_fallFatal   = (r_fallCnt >= FALL_LIM);

  // Contact latches: sticky within a frame, cleared at the frame boundary.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_floorSeen  <= 1'b0;
      r_ropeSeen   <= 1'b0;
      r_hazardSeen <= 1'b0;
    end else if (startOfFrame) begin
      r_floorSeen  <= 1'b0;
      r_ropeSeen   <= 1'b0;
      r_hazardSeen <= 1'b0;
    end else begin
      r_floorSeen  <= w_floor;
      r_ropeSeen   <= w_rope;
      r_hazardSeen <= w_hazard;
    end
  end

  // Jump key history for rising-edge detection.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_keyJumpD <= 1'b0;
    else         r_keyJumpD <= keyJump;
  end

  // Frame counter for RESPAWN/DYING, restarted on every state entry.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      r_frameCnt <= 8'd0;
    else if (w_stateChange)
      r_frameCnt <= 8'd0;
    else if (startOfFrame && r_frameCnt != 8'hFF)
      r_frameCnt <= r_frameCnt + 8'd1;
  end

  // Descending-frame counter in AIR, saturating.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      r_fallCnt <= 8'd0;
    else if (w_stateChange)
      r_fallCnt <= 8'd0;
    else if (r_state == S_AIR && startOfFrame &&
             descending && r_fallCnt != 8'hFF)
      r_fallCnt <= r_fallCnt + 8'd1;
  end

`ifdef MONKEY_JUMP_BUFFER_EN
  localparam logic [3:0] BUF_LOAD = 4'(JUMP_BUFFER_FRAMES);
  logic [3:0] r_bufCnt;

  assign w_bufFire = (r_state == S_AIR) & startOfFrame &
                     (w_next == S_GROUND) & (r_bufCnt != 4'd0);

  // Jump buffer: armed by an AIR jump edge, ages one per frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      r_bufCnt <= 4'd0;
    else if (r_state != S_AIR || w_next != S_AIR)
      r_bufCnt <= 4'd0;
    else if (w_jumpEdge)
      r_bufCnt <= BUF_LOAD;
    else if (startOfFrame && r_bufCnt != 4'd0)
      r_bufCnt <= r_bufCnt - 4'd1;
  end
`else
  assign w_bufFire = 1'b0;
`endif

  // Pending take-off: a jump in GROUND leaves at the next frame boundary.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      r_jumpPending <= 1'b0;
    else if (w_stateChange)
      r_jumpPending <= w_bufFire;
    else if (w_groundJump)
      r_jumpPending <= 1'b1;
  end

  // Next-state and lives logic.
  always_comb begin
    w_next      = r_state;
    w_livesNext = r_lives;
    unique case (r_state)
      S_IDLE, S_GAME_OVER: begin
        if (gameStart) begin
          w_next      = S_RESPAWN;
          w_livesNext = LIVES_INIT;
        end
      end
      S_RESPAWN: begin
        if (w_respDone) w_next = S_AIR;
      end
      S_GROUND: begin
        if (startOfFrame) begin
          if (w_hazard)
            w_next = S_DYING;
          else if (r_jumpPending || w_groundJump)
            w_next = S_AIR;
          else if (w_rope)
            w_next = S_ROPE;
          else if (!w_floor)
            w_next = S_AIR;
        end
      end
      S_AIR: begin
        if (startOfFrame) begin
          if (w_hazard)
            w_next = S_DYING;
          else if (w_rope)
            w_next = S_ROPE;
          else if (w_floor)
            w_next = w_fallFatal ? S_DYING : S_GROUND;
        end
      end
      S_ROPE: begin
        if (startOfFrame) begin
          if (w_hazard)
            w_next = S_DYING;
          else if (!w_rope)
            w_next = w_floor ? S_GROUND : S_AIR;
        end
      end
      S_DYING: begin
        if (w_dyingDone) begin
          if (r_lives != 2'd0)
            w_livesNext = r_lives - 2'd1;
          w_next = (w_livesNext == 2'd0) ? S_GAME_OVER : S_RESPAWN;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, lives and mode-derived registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state      <= S_IDLE;
      r_lives      <= 2'd0;
      r_moveResetN <= 1'b0;
      r_gameOver   <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_lives      <= w_livesNext;
      r_moveResetN <= (w_next != S_IDLE) && (w_next != S_RESPAWN);
      r_gameOver   <= (w_next == S_GAME_OVER);
    end
  end

  // Digit legality for the current mode.
  always_comb begin
    w_digitLegal = 1'b0;
    unique case (r_state)
      S_GROUND, S_AIR:
        w_digitLegal = (keyDigit == 4'd4) || (keyDigit == 4'd6);
      S_ROPE:
        w_digitLegal = (keyDigit == 4'd2) || (keyDigit == 4'd4) ||
                       (keyDigit == 4'd6) || (keyDigit == 4'd8);
      default:
        w_digitLegal = 1'b0;
    endcase
  end

  assign w_digitPass = keyDigitValid & w_digitLegal;

  // Registered command outputs to the movement block.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_digitValid <= 1'b0;
      r_digit      <= 4'd0;
      r_jump       <= 1'b0;
    end else begin
      r_digitValid <= w_digitPass;
      r_digit      <= w_digitPass ? keyDigit : 4'd0;
      r_jump       <= w_groundJump | w_bufFire;
    end
  end

  assign digitIsPressed = r_digitValid;
  assign digit          = r_digit;
  assign jumpIsPressed  = r_jump;
  assign moveResetN     = r_moveResetN;
  assign state          = r_state;
  assign livesLeft      = r_lives;
  assign gameOver       = r_gameOver;

endmodule

// File: tb/tb_monkey_action_ctrl.sv
// Directed bench for monkey_action_ctrl: digit-gating table plus
// hand-written frame sequences for respawn, falls, deaths and jumps.
module tb_monkey_action_ctrl;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       gameStart = 1'b0;
  logic       keyDigitValid = 1'b0;
  logic [3:0] keyDigit = 4'd0;
  logic       keyJump = 1'b0;
  logic       floorHit = 1'b0;
  logic       ropeHit = 1'b0;
  logic       hazardHit = 1'b0;
  logic       descending = 1'b0;
  logic       digitIsPressed;
  logic [3:0] digit;
  logic       jumpIsPressed;
  logic       moveResetN;
  logic [2:0] state;
  logic [1:0] livesLeft;
  logic       gameOver;

`ifdef MONKEY_JUMP_BUFFER_EN
  localparam int BUF_EN = 1;
`else
  localparam int BUF_EN = 0;
`endif

  monkey_action_ctrl dut (
    .clk(clk),
    .resetN(resetN),
    .startOfFrame(startOfFrame),
    .gameStart(gameStart),
    .keyDigitValid(keyDigitValid),
    .keyDigit(keyDigit),
    .keyJump(keyJump),
    .floorHit(floorHit),
    .ropeHit(ropeHit),
    .hazardHit(hazardHit),
    .descending(descending),
    .digitIsPressed(digitIsPressed),
    .digit(digit),
    .jumpIsPressed(jumpIsPressed),
    .moveResetN(moveResetN),
    .state(state),
    .livesLeft(livesLeft),
    .gameOver(gameOver)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int jumpCnt = 0;
  int cnt0;

  always @(negedge clk) if (jumpIsPressed) jumpCnt++;

  typedef struct {
    logic [2:0] st;
    logic       v;
    logic [3:0] d;
    logic       ev;
    logic [3:0] ed;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic frame(input logic fl, input logic ro,
                       input logic hz, input logic de);
    floorHit = fl; ropeHit = ro; hazardHit = hz; descending = de;
    startOfFrame = 1'b0;
    repeat (3) @(negedge clk);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    floorHit = 1'b0; ropeHit = 1'b0; hazardHit = 1'b0; descending = 1'b0;
  endtask

  task automatic frames(input int n, input logic hz, input logic de);
    for (int k = 0; k < n; k++) frame(1'b0, 1'b0, hz, de);
  endtask

  task automatic applyVecs(input logic [2:0] s);
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].st == s) begin
        keyDigitValid = vecs[i].v;
        keyDigit = vecs[i].d;
        @(negedge clk);
        chk($sformatf("dig_valid[%0d]", i), digitIsPressed, vecs[i].ev);
        chk($sformatf("dig_val[%0d]", i), digit, vecs[i].ed);
      end
    end
    keyDigitValid = 1'b0;
    keyDigit = 4'd0;
  endtask

  task automatic pulseStart();
    gameStart = 1'b1;
    @(negedge clk);
    gameStart = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{3'd0, 1'b1, 4'd4, 1'b0, 4'd0};
    vecs[1]  = '{3'd1, 1'b1, 4'd4, 1'b1, 4'd4};
    vecs[2]  = '{3'd1, 1'b1, 4'd6, 1'b1, 4'd6};
    vecs[3]  = '{3'd1, 1'b1, 4'd8, 1'b0, 4'd0};
    vecs[4]  = '{3'd1, 1'b1, 4'd2, 1'b0, 4'd0};
    vecs[5]  = '{3'd1, 1'b0, 4'd4, 1'b0, 4'd0};
    vecs[6]  = '{3'd3, 1'b1, 4'd8, 1'b1, 4'd8};
    vecs[7]  = '{3'd3, 1'b1, 4'd2, 1'b1, 4'd2};
    vecs[8]  = '{3'd3, 1'b1, 4'd5, 1'b0, 4'd0};
    vecs[9]  = '{3'd3, 1'b0, 4'd6, 1'b0, 4'd0};
    vecs[10] = '{3'd3, 1'b1, 4'd4, 1'b1, 4'd4};

    repeat (3) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_lives", livesLeft, 0);
    chk("rst_gameOver", gameOver, 0);
    chk("rst_moveResetN", moveResetN, 0);
    chk("rst_digitValid", digitIsPressed, 0);
    chk("rst_digit", digit, 0);
    chk("rst_jump", jumpIsPressed, 0);
    resetN = 1'b1;
    @(negedge clk);
    applyVecs(3'd0);

    pulseStart();
    chk("start_state", state, 5);
    chk("start_lives", livesLeft, 3);
    chk("start_moveResetN", moveResetN, 0);
    frames(29, 1'b0, 1'b0);
    chk("resp29_state", state, 5);
    chk("resp29_moveResetN", moveResetN, 0);
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    chk("resp30_state", state, 2);
    chk("resp30_moveResetN", moveResetN, 1);

    frames(40, 1'b0, 1'b1);
    chk("fall40_air", state, 2);
    frame(1'b1, 1'b0, 1'b0, 1'b0);
    chk("fall40_state", state, 4);
    frames(44, 1'b0, 1'b0);
    chk("dying44_state", state, 4);
    chk("dying44_lives", livesLeft, 3);
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    chk("dying45_state", state, 5);
    chk("dying45_lives", livesLeft, 2);
    frames(30, 1'b0, 1'b0);
    chk("resp2_state", state, 2);
    frames(39, 1'b0, 1'b1);
    frame(1'b1, 1'b0, 1'b0, 1'b0);
    chk("fall39_state", state, 1);

    applyVecs(3'd1);
    pulseStart();
    chk("start_ign_state", state, 1);
    chk("start_ign_lives", livesLeft, 2);

    #1 cnt0 = jumpCnt;
    keyJump = 1'b1;
    frame(1'b1, 1'b0, 1'b0, 1'b0);
    chk("jump_air_state", state, 2);
    frames(9, 1'b0, 1'b0);
    #1 chk("jump_pulses", jumpCnt - cnt0, 1);
    chk("jump_held_state", state, 2);
    keyJump = 1'b0;

    frame(1'b1, 1'b0, 1'b0, 1'b0);
    chk("land_state", state, 1);
    frame(1'b0, 1'b1, 1'b0, 1'b0);
    chk("rope_state", state, 3);
    applyVecs(3'd3);
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rope_exit_air", state, 2);

    frame(1'b1, 1'b0, 1'b1, 1'b0);
    chk("hz_floor_state", state, 4);
    frames(45, 1'b0, 1'b0);
    chk("death2_state", state, 5);
    chk("death2_lives", livesLeft, 1);
    frames(30, 1'b1, 1'b0);
    chk("resp_hz_ign", state, 2);
    frame(1'b0, 1'b0, 1'b1, 1'b0);
    chk("hz_air_state", state, 4);
    frames(45, 1'b0, 1'b0);
    chk("go_state", state, 6);
    chk("go_lives", livesLeft, 0);
    chk("go_flag", gameOver, 1);
    chk("go_moveResetN", moveResetN, 1);
    pulseStart();
    chk("restart_state", state, 5);
    chk("restart_lives", livesLeft, 3);
    chk("restart_flag", gameOver, 0);
    frames(30, 1'b0, 1'b0);
    chk("restart_air", state, 2);

    keyJump = 1'b1;
    @(negedge clk);
    keyJump = 1'b0;
    #1 cnt0 = jumpCnt;
    frames(7, 1'b0, 1'b0);
    floorHit = 1'b1;
    @(negedge clk);
    floorHit = 1'b0;
    @(negedge clk);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    chk("buf8_land_state", state, 1);
    chk("buf8_jump", jumpIsPressed, 0);
    @(negedge clk);
    #1 chk("buf8_pulses", jumpCnt - cnt0, 0);

    frame(1'b0, 1'b0, 1'b0, 1'b0);
    chk("buf3_air", state, 2);
    keyJump = 1'b1;
    @(negedge clk);
    keyJump = 1'b0;
    #1 cnt0 = jumpCnt;
    frames(2, 1'b0, 1'b0);
    frame(1'b1, 1'b0, 1'b0, 1'b0);
    chk("buf3_land_state", state, 1);
    chk("buf3_jump", jumpIsPressed, BUF_EN);
    @(negedge clk);
    #1 chk("buf3_pulses", jumpCnt - cnt0, BUF_EN);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/monkey_action_ctrl.md
Name: monkey_action_ctrl

Overview:
Per-life action sequencer for the player monkey. It sits between the keyboard decoder and collision logic on one side and the monkey movement/collision datapath on the other. It tracks the monkey's mode (ground, air, rope, dying, respawn) and gates raw key inputs into legal movement commands for that mode. It also owns the death/respawn/lives sequence, restarting the movement block through its moveResetN output.

Parameters:
LIVES, 3, lives loaded on game start (1..3)
RESPAWN_FRAMES, 30, frames moveResetN is held low on respawn (1..255)
DYING_FRAMES, 45, frames spent in DYING before the lives decision (1..255)
FALL_DEATH_FRAMES, 40, descending frames in AIR that are fatal on landing (1..255)
JUMP_BUFFER_FRAMES, 6, jump-buffer window in frames (only with the optional feature; 1..15)

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-clk pulse per frame
gameStart  in  1  one-clk start request
keyDigitValid  in  1  a keypad digit is held
keyDigit  in  4  held digit value
keyJump  in  1  jump key level
floorHit  in  1  monkey bottom edge touching floor (any clk in frame)
ropeHit  in  1  monkey touching rope
hazardHit  in  1  monkey touching enemy/hazard
descending  in  1  monkey Y speed > 0
digitIsPressed  out  1  gated digit-valid to movement block
digit  out  4  gated digit to movement block
jumpIsPressed  out  1  one-clk jump pulse to movement block
moveResetN  out  1  active-low restart of movement block
state  out  3  IDLE=0 GROUND=1 AIR=2 ROPE=3 DYING=4 RESPAWN=5 GAME_OVER=6
livesLeft  out  2  remaining lives
gameOver  out  1  high in GAME_OVER

Behaviour:
- Reset: state=IDLE, livesLeft=0, gameOver=0, moveResetN=0, digitIsPressed=0, digit=0, jumpIsPressed=0. All counters and latches clear. Reset mid-operation aborts to IDLE immediately.
- Frame latches: floorSeen, ropeSeen and hazardSeen are set on any clk where the matching input is high. At startOfFrame the FSM uses the value OR-ed with the same-cycle input, then the latches clear.
- Transitions happen only on startOfFrame unless stated otherwise. Priority at a frame boundary: hazardSeen, then rope, then floor.
- IDLE: all commands masked, moveResetN=0. On gameStart, livesLeft=LIVES and go to RESPAWN on the next clk.
- RESPAWN: moveResetN=0 for RESPAWN_FRAMES frame pulses, then moveResetN=1 and go to AIR. Hazards are ignored.
- GROUND: passes digits 4 and 6 only. A rising edge of keyJump gives jumpIsPressed=1 for exactly one clk, and state goes to AIR at the next frame boundary. Otherwise at the frame boundary: ropeSeen goes to ROPE; no floorSeen goes to AIR.
- AIR: passes digits 4 and 6; jump is masked. fallCnt increments on each frame boundary with descending=1 and saturates at 255. It clears on entry to AIR. At a frame boundary:
  - ropeSeen goes to ROPE.
  - floorSeen goes to DYING if fallCnt >= FALL_DEATH_FRAMES, else GROUND.
- ROPE: passes digits 2, 4, 6 and 8; jump is masked. At a frame boundary with no ropeSeen: floorSeen goes to GROUND, else AIR.
- Hazard: in GROUND, AIR or ROPE, hazardSeen at a frame boundary goes to DYING. This wins over a simultaneous floor or rope.
- DYING: commands masked. After DYING_FRAMES frame pulses, livesLeft decrements (no underflow). Then livesLeft==0 goes to GAME_OVER, else RESPAWN.
- GAME_OVER: gameOver=1, commands masked, moveResetN=1 (sprite stays visible). gameStart reloads lives and goes to RESPAWN. gameStart is ignored in every other state.
- Digit gating: when the digit is illegal for the state, or keyDigitValid=0, outputs digitIsPressed=0 and digit=0. Outputs are registered with 1 clk latency from the inputs.
- Counter widths are 8 bits; frame counters clear on every state entry.

Optional Feature:
MONKEY_JUMP_BUFFER_EN. When defined, a keyJump rising edge in AIR arms a buffer for JUMP_BUFFER_FRAMES frames. Landing in GROUND while the buffer is armed issues jumpIsPressed on the clk after the landing frame boundary and clears the buffer. The buffer also clears on leaving AIR for any other state. When undefined, jump edges in AIR are discarded and no buffer logic is built.

Test Plan:
- Reset, then gameStart pulse -> state=5, moveResetN=0 for 30 frames, then state=2; livesLeft=3.
- In GROUND, keyJump 0->1 held 10 frames -> exactly one jumpIsPressed clk, state=2 next frame; no second pulse while held.
- In AIR, descending=1 for 40 frames, then floorHit -> state=4. Repeat with 39 frames -> state=1.
- In ROPE, keyDigit=8 valid -> digit=8, digitIsPressed=1 after 1 clk. In GROUND, keyDigit=8 -> digitIsPressed=0, digit=0.
- hazardHit and floorHit in the same frame from AIR -> state=4. Three deaths from livesLeft=3 -> state=6, gameOver=1, livesLeft=0. gameStart then gives livesLeft=3, state=5.
- With MONKEY_JUMP_BUFFER_EN, jump edge 3 frames before landing -> jumpIsPressed 1 clk after landing boundary. Edge 8 frames before landing -> no pulse. Without the macro, no pulse in both cases.
